// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX boundary bundle: decoded instruction from ID plus the registered EX copy.
// The master side is the decode stage; the slave side is the pipeline register.
interface id_ex_pipe_reg_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   logic              id_valid;
   logic              RegDst, Branch, MemRead, MemToReg, MemWrite, ALUSrc, RegWrite, Jump;
   logic [2:0]        ALUOp;
   logic [REG_AW-1:0] id_rs, id_rt, id_rd;
   logic [5:0]        id_funct;
   logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm, id_pc4;
   logic              flush;

   logic              stall_ifid;
   logic              ex_valid;
   logic              ex_RegDst, ex_Branch, ex_MemRead, ex_MemToReg;
   logic              ex_MemWrite, ex_ALUSrc, ex_RegWrite, ex_Jump;
   logic [2:0]        ex_ALUOp;
   logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
   logic [5:0]        ex_funct;
   logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
   logic [CNT_W-1:0]  bubble_cnt;

   modport master (
      output id_valid, RegDst, Branch, MemRead, MemToReg, MemWrite, ALUSrc, RegWrite, Jump,
             ALUOp, id_rs, id_rt, id_rd, id_funct, id_rs_data, id_rt_data, id_imm, id_pc4, flush,
      input  stall_ifid, ex_valid, ex_RegDst, ex_Branch, ex_MemRead, ex_MemToReg, ex_MemWrite,
             ex_ALUSrc, ex_RegWrite, ex_Jump, ex_ALUOp, ex_rs, ex_rt, ex_rd, ex_funct,
             ex_rs_data, ex_rt_data, ex_imm, ex_pc4, bubble_cnt
   );

   modport slave (
      input  id_valid, RegDst, Branch, MemRead, MemToReg, MemWrite, ALUSrc, RegWrite, Jump,
             ALUOp, id_rs, id_rt, id_rd, id_funct, id_rs_data, id_rt_data, id_imm, id_pc4, flush,
      output stall_ifid, ex_valid, ex_RegDst, ex_Branch, ex_MemRead, ex_MemToReg, ex_MemWrite,
             ex_ALUSrc, ex_RegWrite, ex_Jump, ex_ALUOp, ex_rs, ex_rt, ex_rd, ex_funct,
             ex_rs_data, ex_rt_data, ex_imm, ex_pc4, bubble_cnt
   );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush squashing
// and a saturating count of injected bubbles.
module id_ex_pipe_reg #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input logic             clk,
   input logic             rst,
   id_ex_pipe_reg_if.slave bus
);

   typedef struct packed {
      logic       regDst;
      logic       branch;
      logic       memRead;
      logic       memToReg;
      logic       memWrite;
      logic       aluSrc;
      logic       regWrite;
      logic       jump;
      logic [2:0] aluOp;
   } ctl_t;

   ctl_t              ctlIn;
   ctl_t              ctl_q, ctl_d;
   logic              valid_q, valid_d;
   logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
   logic [5:0]        funct_q, funct_d;
   logic [DATA_W-1:0] rsData_q, rsData_d, rtData_q, rtData_d, imm_q, imm_d, pc4_q, pc4_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              usesRt;
   logic              loadUse;
   logic              stallIfid;

   assign ctlIn = '{regDst:   bus.RegDst,   branch:   bus.Branch,
                    memRead:  bus.MemRead,  memToReg: bus.MemToReg,
                    memWrite: bus.MemWrite, aluSrc:   bus.ALUSrc,
                    regWrite: bus.RegWrite, jump:     bus.Jump,
                    aluOp:    bus.ALUOp};

   // A load in EX whose destination is read by the ID instruction cannot forward in time.
   assign usesRt    = ~bus.ALUSrc | bus.MemWrite | bus.Branch;
   assign loadUse   = valid_q & ctl_q.memRead & (rt_q != '0) &
                      ((rt_q == bus.id_rs) | (usesRt & (rt_q == bus.id_rt)));
   assign stallIfid = bus.id_valid & loadUse & ~bus.flush & ~rst;

   // Flush outranks stall; both inject a bubble, data fields simply hold.
   always_comb begin
      valid_d  = valid_q;
      ctl_d    = ctl_q;
      rs_d     = rs_q;
      rt_d     = rt_q;
      rd_d     = rd_q;
      funct_d  = funct_q;
      rsData_d = rsData_q;
      rtData_d = rtData_q;
      imm_d    = imm_q;
      pc4_d    = pc4_q;
      cnt_d    = cnt_q;
      if (bus.flush) begin
         valid_d = 1'b0;
         ctl_d   = '0;
      end else if (stallIfid) begin
         valid_d = 1'b0;
         ctl_d   = '0;
         if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         valid_d  = bus.id_valid;
         ctl_d    = bus.id_valid ? ctlIn : '0;
         rs_d     = bus.id_rs;
         rt_d     = bus.id_rt;
         rd_d     = bus.id_rd;
         funct_d  = bus.id_funct;
         rsData_d = bus.id_rs_data;
         rtData_d = bus.id_rt_data;
         imm_d    = bus.id_imm;
         pc4_d    = bus.id_pc4;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= 1'b0;
         ctl_q    <= '0;
         rs_q     <= '0;
         rt_q     <= '0;
         rd_q     <= '0;
         funct_q  <= '0;
         rsData_q <= '0;
         rtData_q <= '0;
         imm_q    <= '0;
         pc4_q    <= '0;
         cnt_q    <= '0;
      end else begin
         valid_q  <= valid_d;
         ctl_q    <= ctl_d;
         rs_q     <= rs_d;
         rt_q     <= rt_d;
         rd_q     <= rd_d;
         funct_q  <= funct_d;
         rsData_q <= rsData_d;
         rtData_q <= rtData_d;
         imm_q    <= imm_d;
         pc4_q    <= pc4_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.stall_ifid  = stallIfid;
   assign bus.ex_valid    = valid_q;
   assign bus.ex_RegDst   = ctl_q.regDst;
   assign bus.ex_Branch   = ctl_q.branch;
   assign bus.ex_MemRead  = ctl_q.memRead;
   assign bus.ex_MemToReg = ctl_q.memToReg;
   assign bus.ex_MemWrite = ctl_q.memWrite;
   assign bus.ex_ALUSrc   = ctl_q.aluSrc;
   assign bus.ex_RegWrite = ctl_q.regWrite;
   assign bus.ex_Jump     = ctl_q.jump;
   assign bus.ex_ALUOp    = ctl_q.aluOp;
   assign bus.ex_rs       = rs_q;
   assign bus.ex_rt       = rt_q;
   assign bus.ex_rd       = rd_q;
   assign bus.ex_funct    = funct_q;
   assign bus.ex_rs_data  = rsData_q;
   assign bus.ex_rt_data  = rtData_q;
   assign bus.ex_imm      = imm_q;
   assign bus.ex_pc4      = pc4_q;
   assign bus.bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: a vector table for the pipeline sequence plus
// hand-written reset, mid-stall reset and counter saturation sequences.
module tb_id_ex_pipe_reg;

   localparam logic [10:0] CRD  = 11'h400;
   localparam logic [10:0] CBR  = 11'h200;
   localparam logic [10:0] CMR  = 11'h100;
   localparam logic [10:0] CMTR = 11'h080;
   localparam logic [10:0] CMW  = 11'h040;
   localparam logic [10:0] CAS  = 11'h020;
   localparam logic [10:0] CRW  = 11'h010;
   localparam logic [10:0] CJ   = 11'h008;
   localparam logic [10:0] LW    = CMR | CMTR | CAS | CRW;
   localparam logic [10:0] ADDI  = CAS | CRW;
   localparam logic [10:0] RTYPE = CRD | CRW | 11'd2;
   localparam logic [10:0] SW    = CMW | CAS;
   localparam logic [10:0] BEQ   = CBR | 11'd1;

   typedef struct {
      logic        valid;
      logic [10:0] ctl;
      logic [4:0]  rs, rt, rd;
      logic [5:0]  funct;
      logic [31:0] rsData, rtData, imm, pc4;
      logic        flush;
   } stim_t;

   typedef struct {
      stim_t       s;
      logic        expStall;
      logic        expValid;
      logic [10:0] expCtl;
      logic [4:0]  expRs, expRt, expRd;
      logic [31:0] expImm, expPc4;
      logic [15:0] expCnt;
   } vec_t;

   logic clock;
   logic reset;
   int   compared;
   int   mismatched;

   id_ex_pipe_reg_if #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) busIf ();
   id_ex_pipe_reg_if #(.DATA_W(32), .REG_AW(5), .CNT_W(2))  satIf ();

   id_ex_pipe_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (
      .clk (clock),
      .rst (reset),
      .bus (busIf.slave)
   );

   id_ex_pipe_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(2)) dutSat (
      .clk (clock),
      .rst (reset),
      .bus (satIf.slave)
   );

   logic [10:0] exCtlMain;
   assign exCtlMain = {busIf.ex_RegDst, busIf.ex_Branch, busIf.ex_MemRead, busIf.ex_MemToReg,
                       busIf.ex_MemWrite, busIf.ex_ALUSrc, busIf.ex_RegWrite, busIf.ex_Jump,
                       busIf.ex_ALUOp};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Operand data is derived from the register indices so held fields can be predicted.
   function automatic stim_t mkStim(input logic valid, input logic [10:0] ctl, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] imm,
                                    input logic [31:0] pc4, input logic flush);
      stim_t s;
      s.valid  = valid;
      s.ctl    = ctl;
      s.rs     = rs;
      s.rt     = rt;
      s.rd     = rd;
      s.funct  = pc4[7:2];
      s.rsData = 32'hA000_0000 | {27'h0, rs};
      s.rtData = 32'hB000_0000 | {27'h0, rt};
      s.imm    = imm;
      s.pc4    = pc4;
      s.flush  = flush;
      return s;
   endfunction

   function automatic vec_t mkVec(input stim_t s, input logic stall, input logic valid,
                                  input logic [10:0] ctl, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic [31:0] imm, input logic [31:0] pc4,
                                  input logic [15:0] cnt);
      vec_t v;
      v.s        = s;
      v.expStall = stall;
      v.expValid = valid;
      v.expCtl   = ctl;
      v.expRs    = rs;
      v.expRt    = rt;
      v.expRd    = rd;
      v.expImm   = imm;
      v.expPc4   = pc4;
      v.expCnt   = cnt;
      return v;
   endfunction

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input stim_t s);
      busIf.id_valid   = s.valid;
      {busIf.RegDst, busIf.Branch, busIf.MemRead, busIf.MemToReg, busIf.MemWrite,
       busIf.ALUSrc, busIf.RegWrite, busIf.Jump, busIf.ALUOp} = s.ctl;
      busIf.id_rs      = s.rs;
      busIf.id_rt      = s.rt;
      busIf.id_rd      = s.rd;
      busIf.id_funct   = s.funct;
      busIf.id_rs_data = s.rsData;
      busIf.id_rt_data = s.rtData;
      busIf.id_imm     = s.imm;
      busIf.id_pc4     = s.pc4;
      busIf.flush      = s.flush;
      satIf.id_valid   = s.valid;
      {satIf.RegDst, satIf.Branch, satIf.MemRead, satIf.MemToReg, satIf.MemWrite,
       satIf.ALUSrc, satIf.RegWrite, satIf.Jump, satIf.ALUOp} = s.ctl;
      satIf.id_rs      = s.rs;
      satIf.id_rt      = s.rt;
      satIf.id_rd      = s.rd;
      satIf.id_funct   = s.funct;
      satIf.id_rs_data = s.rsData;
      satIf.id_rt_data = s.rtData;
      satIf.id_imm     = s.imm;
      satIf.id_pc4     = s.pc4;
      satIf.flush      = s.flush;
   endtask

   task automatic checkOutput(input string tag, input vec_t v);
      cmp({tag, ".ex_valid"},   64'(busIf.ex_valid),   64'(v.expValid));
      cmp({tag, ".ex_ctl"},     64'(exCtlMain),        64'(v.expCtl));
      cmp({tag, ".ex_rs"},      64'(busIf.ex_rs),      64'(v.expRs));
      cmp({tag, ".ex_rt"},      64'(busIf.ex_rt),      64'(v.expRt));
      cmp({tag, ".ex_rd"},      64'(busIf.ex_rd),      64'(v.expRd));
      cmp({tag, ".ex_funct"},   64'(busIf.ex_funct),   64'(v.expPc4[7:2]));
      cmp({tag, ".ex_rs_data"}, 64'(busIf.ex_rs_data), 64'(32'hA000_0000 | {27'h0, v.expRs}));
      cmp({tag, ".ex_rt_data"}, 64'(busIf.ex_rt_data), 64'(32'hB000_0000 | {27'h0, v.expRt}));
      cmp({tag, ".ex_imm"},     64'(busIf.ex_imm),     64'(v.expImm));
      cmp({tag, ".ex_pc4"},     64'(busIf.ex_pc4),     64'(v.expPc4));
      cmp({tag, ".bubble_cnt"}, 64'(busIf.bubble_cnt), 64'(v.expCnt));
   endtask

   task automatic checkZero(input string tag);
      cmp({tag, ".ex_valid"},   64'(busIf.ex_valid),   64'd0);
      cmp({tag, ".ex_ctl"},     64'(exCtlMain),        64'd0);
      cmp({tag, ".ex_rs"},      64'(busIf.ex_rs),      64'd0);
      cmp({tag, ".ex_rt"},      64'(busIf.ex_rt),      64'd0);
      cmp({tag, ".ex_rd"},      64'(busIf.ex_rd),      64'd0);
      cmp({tag, ".ex_funct"},   64'(busIf.ex_funct),   64'd0);
      cmp({tag, ".ex_rs_data"}, 64'(busIf.ex_rs_data), 64'd0);
      cmp({tag, ".ex_rt_data"}, 64'(busIf.ex_rt_data), 64'd0);
      cmp({tag, ".ex_imm"},     64'(busIf.ex_imm),     64'd0);
      cmp({tag, ".ex_pc4"},     64'(busIf.ex_pc4),     64'd0);
      cmp({tag, ".bubble_cnt"}, 64'(busIf.bubble_cnt), 64'd0);
      cmp({tag, ".stall_ifid"}, 64'(busIf.stall_ifid), 64'd0);
      cmp({tag, ".sat_cnt"},    64'(satIf.bubble_cnt), 64'd0);
      cmp({tag, ".sat_valid"},  64'(satIf.ex_valid),   64'd0);
   endtask

   function automatic stim_t randStim();
      stim_t s;
      s.valid  = 1'b1;
      s.ctl    = 11'($urandom);
      s.rs     = 5'($urandom);
      s.rt     = 5'($urandom);
      s.rd     = 5'($urandom);
      s.funct  = 6'($urandom);
      s.rsData = $urandom;
      s.rtData = $urandom;
      s.imm    = $urandom;
      s.pc4    = $urandom;
      s.flush  = 1'b0;
      return s;
   endfunction

   vec_t vecs[17];

   initial begin
      compared   = 0;
      mismatched = 0;

      vecs[0]  = mkVec(mkStim(1, ADDI, 3, 8, 0, 32'h5, 32'h104, 0),            0, 1, ADDI,  3, 8, 0, 32'h5, 32'h104, 0);
      vecs[1]  = mkVec(mkStim(1, LW, 2, 9, 0, 32'h4, 32'h108, 0),              0, 1, LW,    2, 9, 0, 32'h4, 32'h108, 0);
      vecs[2]  = mkVec(mkStim(1, RTYPE, 9, 10, 11, 32'h0, 32'h10C, 0),         1, 0, 11'd0, 2, 9, 0, 32'h4, 32'h108, 1);
      vecs[3]  = mkVec(mkStim(1, RTYPE, 9, 10, 11, 32'h0, 32'h10C, 0),         0, 1, RTYPE, 9, 10, 11, 32'h0, 32'h10C, 1);
      vecs[4]  = mkVec(mkStim(1, LW, 4, 0, 0, 32'h8, 32'h110, 0),              0, 1, LW,    4, 0, 0, 32'h8, 32'h110, 1);
      vecs[5]  = mkVec(mkStim(1, RTYPE, 0, 0, 12, 32'h0, 32'h114, 0),          0, 1, RTYPE, 0, 0, 12, 32'h0, 32'h114, 1);
      vecs[6]  = mkVec(mkStim(1, LW, 5, 9, 0, 32'hC, 32'h118, 0),              0, 1, LW,    5, 9, 0, 32'hC, 32'h118, 1);
      vecs[7]  = mkVec(mkStim(1, ADDI, 7, 9, 0, 32'h1, 32'h11C, 0),            0, 1, ADDI,  7, 9, 0, 32'h1, 32'h11C, 1);
      vecs[8]  = mkVec(mkStim(1, LW, 1, 9, 0, 32'h10, 32'h120, 0),             0, 1, LW,    1, 9, 0, 32'h10, 32'h120, 1);
      vecs[9]  = mkVec(mkStim(1, SW, 2, 9, 0, 32'h14, 32'h124, 1),             0, 0, 11'd0, 1, 9, 0, 32'h10, 32'h120, 1);
      vecs[10] = mkVec(mkStim(1, SW, 2, 9, 0, 32'h14, 32'h124, 0),             0, 1, SW,    2, 9, 0, 32'h14, 32'h124, 1);
      vecs[11] = mkVec(mkStim(0, CRW | CJ | CBR, 9, 3, 0, 32'h24, 32'h128, 0), 0, 0, 11'd0, 9, 3, 0, 32'h24, 32'h128, 1);
      vecs[12] = mkVec(mkStim(1, LW, 1, 6, 0, 32'h0, 32'h12C, 0),              0, 1, LW,    1, 6, 0, 32'h0, 32'h12C, 1);
      vecs[13] = mkVec(mkStim(1, BEQ, 3, 6, 0, 32'hFFFF_FFFC, 32'h130, 0),     1, 0, 11'd0, 1, 6, 0, 32'h0, 32'h12C, 2);
      vecs[14] = mkVec(mkStim(1, BEQ, 3, 6, 0, 32'hFFFF_FFFC, 32'h130, 0),     0, 1, BEQ,   3, 6, 0, 32'hFFFF_FFFC, 32'h130, 2);
      vecs[15] = mkVec(mkStim(1, LW, 0, 9, 0, 32'h0, 32'h134, 0),              0, 1, LW,    0, 9, 0, 32'h0, 32'h134, 2);
      vecs[16] = mkVec(mkStim(0, RTYPE, 9, 0, 13, 32'h0, 32'h138, 0),          0, 0, 11'd0, 9, 0, 13, 32'h0, 32'h138, 2);

      // Power-on reset with random inputs in flight.
      reset = 1'b1;
      applyStimulus(randStim());
      #3;
      checkZero("por");
      @(posedge clock);
      applyStimulus(randStim());
      #1;
      checkZero("por_edge");
      @(negedge clock);
      reset = 1'b0;

      // Vector table: stall sampled before the edge, registered outputs just after.
      for (int i = 0; i < 17; i++) begin
         @(negedge clock);
         applyStimulus(vecs[i].s);
         #1;
         cmp($sformatf("v%0d.stall_ifid", i), 64'(busIf.stall_ifid), 64'(vecs[i].expStall));
         @(posedge clock);
         #1;
         checkOutput($sformatf("v%0d", i), vecs[i]);
      end

      // Reset in the middle of a stall cycle, then a normal capture.
      @(negedge clock);
      applyStimulus(mkStim(1, LW, 1, 9, 0, 32'h0, 32'h200, 0));
      @(posedge clock);
      @(negedge clock);
      applyStimulus(mkStim(1, RTYPE, 9, 4, 5, 32'h0, 32'h204, 0));
      #1;
      cmp("midstall.pre_stall", 64'(busIf.stall_ifid), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      checkZero("midstall.rst");
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      cmp("midstall.post_stall", 64'(busIf.stall_ifid), 64'd0);
      @(posedge clock);
      #1;
      checkOutput("midstall.cap", mkVec(mkStim(1, RTYPE, 9, 4, 5, 32'h0, 32'h204, 0),
                                        0, 1, RTYPE, 9, 4, 5, 32'h0, 32'h204, 0));

      // Five back-to-back load-use pairs: the 2-bit counter must stick at 3.
      for (int k = 1; k <= 5; k++) begin
         @(negedge clock);
         applyStimulus(mkStim(1, LW, 1, 9, 0, 32'h0, 32'h300, 0));
         @(posedge clock);
         @(negedge clock);
         applyStimulus(mkStim(1, RTYPE, 9, 2, 3, 32'h0, 32'h304, 0));
         #1;
         cmp($sformatf("sat%0d.stall", k), 64'(satIf.stall_ifid), 64'd1);
         @(posedge clock);
         #1;
         cmp($sformatf("sat%0d.sat_cnt", k),  64'(satIf.bubble_cnt), 64'((k > 3) ? 3 : k));
         cmp($sformatf("sat%0d.main_cnt", k), 64'(busIf.bubble_cnt), 64'(k));
         cmp($sformatf("sat%0d.regwrite", k), 64'(satIf.ex_RegWrite), 64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
